onectr_scheduler: RTL and testbench
===================================

Name: onectr_scheduler

Overview:
- Shares one ones-counter datapath (INPUTSIZE-bit word in, $clog2(INPUTSIZE+1)-bit population count out) between NREQ requesters.
- Round-robin arbitration; drives the counter start pulse and operand; waits for done with a timeout; returns the count tagged with the requester id.
- Sits between requester logic and a single counter instance.

Parameters:
- INPUTSIZE, 64, operand width in bits; CW = $clog2(INPUTSIZE+1).
- NREQ, 4, number of requesters (>=2); IW = $clog2(NREQ).
- TIMEOUT, 255, maximum WAIT cycles before abort (>=1); timer width $clog2(TIMEOUT+1).

Ports:
- clk, in, 1: single clock, rising edge.
- rst, in, 1: reset, synchronous, active-low.
- req_valid_i, in, NREQ: request valid, one bit per requester.
- req_ready_o, out, NREQ: request accepted; one-hot or zero.
- req_data_i, in, NREQ*INPUTSIZE: requester k operand at [k*INPUTSIZE +: INPUTSIZE].
- ctr_start_o, out, 1: one-cycle start pulse to the counter.
- ctr_data_o, out, INPUTSIZE: operand to the counter, held stable START through WAIT.
- ctr_done_i, in, 1: counter result valid (one-cycle pulse).
- ctr_result_i, in, CW: counter result.
- rsp_valid_o, out, 1: response valid.
- rsp_ready_i, in, 1: response accepted.
- rsp_id_o, out, IW: requester index of the response.
- rsp_count_o, out, CW: ones count (0 on error).
- rsp_error_o, out, 1: timeout flag.
- busy_o, out, 1: high in any state except IDLE.

Behaviour:
- Reset (rst=0 at a clock edge):
  - FSM goes to IDLE.
  - All outputs are 0, including ctr_data_o, rsp_* and busy_o.
  - Round-robin pointer last = NREQ-1, so requester 0 has first priority.
  - Reset overrides any state, including mid-WAIT; a late ctr_done_i after reset is ignored.
- FSM states: IDLE, START, WAIT, RESP.
- IDLE:
  - If any req_valid_i is set, winner g = first set bit searching last+1, last+2, … (mod NREQ).
  - req_ready_o[g] = 1 combinationally in the same cycle; handshake completes at that edge.
  - On the handshake: latch req_data_i[g] into ctr_data_o, latch g, go to START.
  - With no valid requests, stay in IDLE with req_ready_o = 0.
- START:
  - ctr_start_o = 1 for exactly this one cycle.
  - Clear the timer and go to WAIT.
- WAIT:
  - On ctr_done_i = 1: latch ctr_result_i into rsp_count_o, set rsp_error_o = 0, go to RESP.
  - Otherwise the timer increments. When the timer equals TIMEOUT-1 and done is still absent: rsp_count_o = 0, rsp_error_o = 1, go to RESP.
  - WAIT therefore lasts at most TIMEOUT cycles.
  - If done arrives in the same cycle as the timeout condition, done wins (no error).
- RESP:
  - rsp_valid_o = 1, with rsp_id_o, rsp_count_o and rsp_error_o held stable until rsp_ready_i = 1.
  - On that handshake: last = rsp_id_o, rsp_valid_o drops, go to IDLE.
  - The next grant happens no earlier than the following cycle.
- ctr_done_i outside WAIT is ignored.
- req_ready_o is 0 in every state except IDLE; only one transaction is ever in flight.
- ctr_data_o keeps its last value after RESP; it is don't-care outside START/WAIT but must not change there.
- Minimum latency is 4 cycles from request handshake to rsp_valid_o, with done in the first WAIT cycle: accept, START, WAIT, RESP.
- Fairness: with all requesters continuously valid, the grant order is 0,1,…,NREQ-1,0,…
- The pointer updates only on response handshake, so timed-out requests still advance it.

Test Plan:
- Req0 only, data=0x00000000000000FF; counter model raises done 3 cycles after start with result 8 -> ctr_start_o high exactly 1 cycle; ctr_data_o=0xFF through WAIT; rsp id=0, count=8, error=0.
- All four req_valid_i held high, distinct operands (popcounts 1,2,3,4); rsp_ready_i=1 -> responses in id order 0,1,2,3,0 with counts 1,2,3,4,1; req_ready_o always one-hot.
- TIMEOUT=16, counter never asserts done -> rsp error=1, count=0 after exactly 16 WAIT cycles; next pending request is then served normally. Same bench with done at WAIT cycle 16 -> error=0.
- Hold rsp_ready_i=0 for 10 cycles in RESP with other requests pending -> rsp_* stable; req_ready_o=0 and ctr_start_o=0 throughout.
- Drive rst=0 for one cycle mid-WAIT, with a late ctr_done_i the cycle after -> all outputs 0; no response emitted; next grant goes to req0 when req0 and req2 are both valid.
- Operand all zeros -> count 0; all ones (INPUTSIZE=64) -> count 64, full CW=7 width, no truncation.

Source files
------------

// File: rtl/onectr_scheduler.sv
// onectr_scheduler
//   Shares a single ones-counter datapath between NREQ requesters. A
//   round-robin arbiter picks one requester and sends a one-cycle start
//   pulse plus the operand to the counter. It then waits for done, or
//   aborts with an error after TIMEOUT cycles. Finally it returns the
//   count, tagged with the requester index. Only one transaction is ever
//   in flight.
//
// Ports
//   clk           rising-edge clock
//   rst           synchronous active-low reset
//   req_valid_i   per-requester request valid
//   req_ready_o   per-requester accept (one-hot or zero, IDLE only)
//   req_data_i    packed operands, requester k at [k*INPUTSIZE +: INPUTSIZE]
//   ctr_start_o   one-cycle start pulse to the counter
//   ctr_data_o    operand to the counter, stable through START and WAIT
//   ctr_done_i    counter result valid (pulse)
//   ctr_result_i  counter population count
//   rsp_valid_o   response valid
//   rsp_ready_i   response accepted
//   rsp_id_o      requester index of the response
//   rsp_count_o   ones count (0 on timeout)
//   rsp_error_o   timeout flag
//   busy_o        high whenever the scheduler is not IDLE
module onectr_scheduler #(
  parameter int INPUTSIZE = 64,
  parameter int NREQ      = 4,
  parameter int TIMEOUT   = 255,
  localparam int CW = $clog2(INPUTSIZE + 1),
  localparam int IW = $clog2(NREQ),
  localparam int TW = $clog2(TIMEOUT + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid_i,
  output logic [NREQ-1:0]           req_ready_o,
  input  logic [NREQ*INPUTSIZE-1:0] req_data_i,
  output logic                      ctr_start_o,
  output logic [INPUTSIZE-1:0]      ctr_data_o,
  input  logic                      ctr_done_i,
  input  logic [CW-1:0]             ctr_result_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [IW-1:0]             rsp_id_o,
  output logic [CW-1:0]             rsp_count_o,
  output logic                      rsp_error_o,
  output logic                      busy_o
);

  typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

  state_t         state;
  state_t         state_next;
  logic [IW-1:0]  last_q;
  logic [TW-1:0]  timer_q;
  logic           grant_valid;
  logic [IW-1:0]  grant_idx;
  logic [IW-1:0]  cand;
  logic           timeout_hit;

  // Round-robin winner: first valid requester found when searching
  // last+1, last+2, ... modulo NREQ. The first hit wins, so later
  // candidates cannot override it.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = IW'((int'(last_q) + i) % NREQ);
      if (!grant_valid && req_valid_i[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Timer counts completed WAIT cycles from 0. Reaching TIMEOUT-1
  // without done therefore bounds WAIT at TIMEOUT cycles.
  assign timeout_hit = (timer_q == TW'(TIMEOUT - 1));

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; done takes priority over a simultaneous timeout
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant_valid) state_next = START;
      START:   state_next = WAIT;
      WAIT:    if (ctr_done_i || timeout_hit) state_next = RESP;
      RESP:    if (rsp_ready_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State-decoded outputs. Ready is masked during reset so a request
  // cannot see a handshake that the FSM will never act on.
  always_comb begin
    req_ready_o = '0;
    if (rst && state == IDLE && grant_valid) begin
      req_ready_o[grant_idx] = 1'b1;
    end
    ctr_start_o = (state == START);
    rsp_valid_o = (state == RESP);
    busy_o      = (state != IDLE);
  end

  // Datapath registers. The operand and id are captured at the grant.
  // The result or error is captured when WAIT exits. The pointer moves
  // only on the response handshake, so timed-out requests advance it
  // too.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ctr_data_o  <= '0;
      rsp_id_o    <= '0;
      rsp_count_o <= '0;
      rsp_error_o <= 1'b0;
      timer_q     <= '0;
      last_q      <= IW'(NREQ - 1);
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid) begin
            ctr_data_o <= req_data_i[grant_idx*INPUTSIZE +: INPUTSIZE];
            rsp_id_o   <= grant_idx;
          end
        end
        START: begin
          timer_q <= '0;
        end
        WAIT: begin
          if (ctr_done_i) begin
            rsp_count_o <= ctr_result_i;
            rsp_error_o <= 1'b0;
          end else if (timeout_hit) begin
            rsp_count_o <= '0;
            rsp_error_o <= 1'b1;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            last_q <= rsp_id_o;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_onectr_scheduler.sv
// tb_onectr_scheduler
//   Drives onectr_scheduler one transaction at a time while playing the
//   role of the ones counter. Expected grants, counts, error flags and
//   cycle-by-cycle outputs come from a round-robin/popcount reference
//   model held here. Directed scenarios are followed by a randomized run.
module tb_onectr_scheduler;

  localparam int INPUTSIZE = 64;
  localparam int NREQ      = 4;
  localparam int TIMEOUT   = 16;
  localparam int CW        = $clog2(INPUTSIZE + 1);
  localparam int IW        = $clog2(NREQ);

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NREQ-1:0]           req_valid_i;
  logic [NREQ-1:0]           req_ready_o;
  logic [NREQ*INPUTSIZE-1:0] req_data_i;
  logic                      ctr_start_o;
  logic [INPUTSIZE-1:0]      ctr_data_o;
  logic                      ctr_done_i;
  logic [CW-1:0]             ctr_result_i;
  logic                      rsp_valid_o;
  logic                      rsp_ready_i;
  logic [IW-1:0]             rsp_id_o;
  logic [CW-1:0]             rsp_count_o;
  logic                      rsp_error_o;
  logic                      busy_o;

  int checks = 0;
  int errors = 0;

  // Reference model state and the current stimulus
  int                   modelLast;
  logic [INPUTSIZE-1:0] stimData [NREQ];
  logic [NREQ-1:0]      stimValid;
  int                   stimDoneAt;
  int                   stimHold;
  int                   stimAbortAt;
  bit                   stimScramble;

  onectr_scheduler #(
    .INPUTSIZE(INPUTSIZE),
    .NREQ(NREQ),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid_i(req_valid_i),
    .req_ready_o(req_ready_o),
    .req_data_i(req_data_i),
    .ctr_start_o(ctr_start_o),
    .ctr_data_o(ctr_data_o),
    .ctr_done_i(ctr_done_i),
    .ctr_result_i(ctr_result_i),
    .rsp_valid_o(rsp_valid_o),
    .rsp_ready_i(rsp_ready_i),
    .rsp_id_o(rsp_id_o),
    .rsp_count_o(rsp_count_o),
    .rsp_error_o(rsp_error_o),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  // Compare one observed value against the model and count it
  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
               tag, actual, expected, $time);
    end
  endtask

  function automatic int popCount(input logic [INPUTSIZE-1:0] w);
    int n = 0;
    for (int i = 0; i < INPUTSIZE; i++) if (w[i]) n++;
    return n;
  endfunction

  function automatic int pickWinner(input logic [NREQ-1:0] v, input int last);
    for (int off = 1; off <= NREQ; off++) begin
      int idx = (last + off) % NREQ;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [INPUTSIZE-1:0] randomOperand();
    case ($urandom_range(0, 3))
      0:       return '0;
      1:       return '1;
      2:       return 64'(1) << $urandom_range(0, INPUTSIZE - 1);
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // Reset pulse while the counter is mid-WAIT, then a late done
  task automatic doReset();
    rst         = 1'b0;
    req_valid_i = '0;
    @(negedge clk);
    rst          = 1'b1;
    ctr_done_i   = 1'b1;
    ctr_result_i = CW'(5);
    #1;
    checkOutput("rst_busy", busy_o, 0);
    checkOutput("rst_rsp_valid", rsp_valid_o, 0);
    checkOutput("rst_rsp_id", rsp_id_o, 0);
    checkOutput("rst_rsp_count", rsp_count_o, 0);
    checkOutput("rst_rsp_error", rsp_error_o, 0);
    checkOutput("rst_start", ctr_start_o, 0);
    checkOutput("rst_ctr_data", ctr_data_o, 0);
    checkOutput("rst_ready", req_ready_o, 0);
    @(negedge clk);
    ctr_done_i = 1'b0;
    #1;
    checkOutput("late_done_valid", rsp_valid_o, 0);
    checkOutput("late_done_busy", busy_o, 0);
    modelLast = NREQ - 1;
  endtask

  // Runs one full transaction from IDLE, checking every cycle
  task automatic serveOne();
    int                   g;
    int                   expCount;
    bit                   expErr;
    logic [INPUTSIZE-1:0] operand;
    #1;
    if (stimValid == '0) begin
      checkOutput("idle_ready", req_ready_o, 0);
      checkOutput("idle_busy", busy_o, 0);
      @(negedge clk);
      return;
    end
    g        = pickWinner(stimValid, modelLast);
    operand  = stimData[g];
    expErr   = (stimDoneAt > TIMEOUT);
    expCount = expErr ? 0 : popCount(operand);
    checkOutput("grant", req_ready_o, 64'(1) << g);
    checkOutput("idle_busy", busy_o, 0);
    checkOutput("idle_rsp_valid", rsp_valid_o, 0);
    @(negedge clk);
    #1;
    checkOutput("start_pulse", ctr_start_o, 1);
    checkOutput("start_data", ctr_data_o, operand);
    checkOutput("start_ready", req_ready_o, 0);
    checkOutput("start_busy", busy_o, 1);
    for (int k = 1; k <= TIMEOUT; k++) begin
      @(negedge clk);
      ctr_done_i = 1'b0;
      if (stimScramble) req_data_i[g*INPUTSIZE +: INPUTSIZE] = {$urandom, $urandom};
      #1;
      checkOutput("wait_start", ctr_start_o, 0);
      checkOutput("wait_data", ctr_data_o, operand);
      checkOutput("wait_rsp_valid", rsp_valid_o, 0);
      checkOutput("wait_ready", req_ready_o, 0);
      if (k == stimAbortAt) begin
        doReset();
        return;
      end
      if (k == stimDoneAt) begin
        ctr_done_i   = 1'b1;
        ctr_result_i = CW'(expCount);
        break;
      end
    end
    @(negedge clk);
    ctr_done_i = 1'b0;
    for (int h = 0; h <= stimHold; h++) begin
      #1;
      checkOutput("rsp_valid", rsp_valid_o, 1);
      checkOutput("rsp_id", rsp_id_o, g);
      checkOutput("rsp_count", rsp_count_o, expCount);
      checkOutput("rsp_error", rsp_error_o, expErr);
      checkOutput("rsp_ready_blocked", req_ready_o, 0);
      checkOutput("rsp_start", ctr_start_o, 0);
      checkOutput("rsp_busy", busy_o, 1);
      if (h < stimHold) begin
        ctr_done_i   = 1'($urandom_range(0, 1));
        ctr_result_i = CW'($urandom);
        @(negedge clk);
        ctr_done_i = 1'b0;
      end
    end
    rsp_ready_i = 1'b1;
    @(negedge clk);
    rsp_ready_i = 1'b0;
    modelLast   = g;
    #1;
    checkOutput("after_rsp_valid", rsp_valid_o, 0);
    checkOutput("after_rsp_busy", busy_o, 0);
  endtask

  task automatic applyStimulus(input logic [NREQ-1:0] valid, input int doneAt,
                               input int hold, input int abortAt, input bit scramble);
    stimValid    = valid;
    stimDoneAt   = doneAt;
    stimHold     = hold;
    stimAbortAt  = abortAt;
    stimScramble = scramble;
    req_valid_i  = valid;
    for (int k = 0; k < NREQ; k++) req_data_i[k*INPUTSIZE +: INPUTSIZE] = stimData[k];
    ctr_done_i  = 1'b0;
    rsp_ready_i = 1'b0;
    serveOne();
  endtask

  initial begin
    rst          = 1'b0;
    req_valid_i  = '0;
    req_data_i   = '0;
    ctr_done_i   = 1'b0;
    ctr_result_i = '0;
    rsp_ready_i  = 1'b0;
    for (int k = 0; k < NREQ; k++) stimData[k] = '0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset_busy", busy_o, 0);
    checkOutput("reset_rsp_valid", rsp_valid_o, 0);
    checkOutput("reset_ready", req_ready_o, 0);
    checkOutput("reset_start", ctr_start_o, 0);
    checkOutput("reset_ctr_data", ctr_data_o, 0);
    checkOutput("reset_rsp_count", rsp_count_o, 0);
    rst       = 1'b1;
    modelLast = NREQ - 1;
    @(negedge clk);

    // All requesters valid: grant order 0,1,2,3,0 with counts 1,2,3,4,1
    stimData[0] = 64'h1;
    stimData[1] = 64'h3;
    stimData[2] = 64'h7;
    stimData[3] = 64'hF;
    for (int t = 0; t < 5; t++) applyStimulus(4'b1111, 1, 0, 0, 0);

    // Req0 alone, done three cycles after start
    stimData[0] = 64'hFF;
    applyStimulus(4'b0001, 3, 0, 0, 0);

    // Timeout, then the next pending request, then done on the last WAIT cycle
    applyStimulus(4'b0110, TIMEOUT + 1, 0, 0, 0);
    applyStimulus(4'b0110, 2, 0, 0, 0);
    applyStimulus(4'b1000, TIMEOUT, 0, 0, 0);

    // Response back-pressure with other requests pending
    applyStimulus(4'b1111, 4, 10, 0, 0);

    // Operand extremes
    stimData[1] = '0;
    applyStimulus(4'b0010, 1, 0, 0, 0);
    stimData[2] = '1;
    applyStimulus(4'b0100, 1, 0, 0, 0);

    // Reset mid-WAIT must restore requester 0 priority
    stimData[0] = 64'h0123_4567_89AB_CDEF;
    applyStimulus(4'b0001, 5, 0, 0, 0);
    applyStimulus(4'b0100, 5, 0, 2, 0);
    applyStimulus(4'b0101, 1, 0, 0, 0);

    // Randomized traffic
    for (int t = 0; t < 60; t++) begin
      int doneAt;
      for (int k = 0; k < NREQ; k++) stimData[k] = randomOperand();
      doneAt = ($urandom_range(0, 3) != 0) ? $urandom_range(1, 4)
                                           : $urandom_range(1, TIMEOUT + 1);
      applyStimulus(NREQ'($urandom_range(0, 15)), doneAt, $urandom_range(0, 3), 0, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
